// File: rtl/clock_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_spi_pkg                                              |
// | Brief   : Shared types and constants for the CDCE62005 cmd sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package clock_spi_pkg;

    localparam int unsigned c_TMR_W   = 16;
    localparam int unsigned c_LEVEL_W = 5;
    localparam logic [3:0]  c_RD_CMD  = 4'he;

    typedef logic [c_TMR_W-1:0] tmr_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CAPTURE   = 3'd5,
        ST_GAP       = 3'd6
    } seq_state_t;

    function automatic logic is_read_cmd(input logic [31:0] word);
        return word[3:0] == c_RD_CMD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_spi_cmd_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_spi_cmd_seq_if                                       |
// | Brief   : Command, SPI-controller and response signals of sequencer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface clock_spi_cmd_seq_if;
    import clock_spi_pkg::*;

    logic                 cmd_wr;
    logic [31:0]          cmd_data;
    logic                 cmd_full;
    logic [c_LEVEL_W-1:0] cmd_level;
    logic                 spi_start;
    logic [31:0]          spi_write_data;
    logic                 spi_busy;
    logic [31:0]          spi_read_data;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_ack;
    logic                 timeout_err;
    logic                 err_clr;
    logic                 seq_idle;

    modport slave (
        input  cmd_wr, cmd_data, spi_busy, spi_read_data, rsp_ack, err_clr,
        output cmd_full, cmd_level, spi_start, spi_write_data,
               rsp_valid, rsp_data, timeout_err, seq_idle
    );

    modport master (
        output cmd_wr, cmd_data, spi_busy, spi_read_data, rsp_ack, err_clr,
        input  cmd_full, cmd_level, spi_start, spi_write_data,
               rsp_valid, rsp_data, timeout_err, seq_idle
    );

endinterface
`default_nettype wire

// File: rtl/clock_spi_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_spi_cmd_fifo                                         |
// | Brief   : Show-ahead synchronous command FIFO with level and full    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clock_spi_cmd_fifo
    import clock_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_wr,
    input  wire logic [DATA_W-1:0]    i_wr_data,
    input  wire logic                 i_rd,
    output logic      [DATA_W-1:0]    o_rd_data,
    output logic                      o_empty,
    output logic                      o_full,
    output logic      [c_LEVEL_W-1:0] o_level
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_LEVEL_W-1:0] c_FULL_LEVEL = c_LEVEL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LEVEL_W-1:0] r_level;
    logic                 w_push;
    logic                 w_pop;

    assign o_full    = (r_level == c_FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Writes while full are dropped so the stored contents never change
    assign w_push = i_wr && !o_full;
    assign w_pop  = i_rd && !o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_W'(1);
                2'b01:   r_level <= r_level - c_LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/clock_spi_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_spi_cmd_seq                                          |
// | Brief   : Queues SPI command words and sequences them into the       |
// |           CDCE62005 SPI controller, capturing read responses         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clock_spi_cmd_seq
    import clock_spi_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         START_WIDTH  = 3,
    parameter tmr_t       ACK_TIMEOUT  = 16'd64,
    parameter tmr_t       DONE_TIMEOUT = 16'd60000,
    parameter logic [7:0] GAP_CYCLES   = 8'd8
) (
    input wire logic            FPGA_48MHz,
    input wire logic            FPGA_rst,
    clock_spi_cmd_seq_if.slave  bus
);

    localparam tmr_t c_START_W = tmr_t'(START_WIDTH);

    seq_state_t   r_state;
    seq_state_t   w_state_nxt;
    tmr_t         r_tmr;
    logic [31:0]  r_wr_data;
    logic [31:0]  r_rsp_data;
    logic         r_spi_start;
    logic         r_rsp_valid;
    logic         r_timeout_err;

    logic         w_pop;
    logic         w_fifo_empty;
    logic [31:0]  w_fifo_data;
    logic         w_set_err;
    logic         w_set_rsp;
    logic [c_TMR_W:0] w_tmr_inc;
    logic         w_start_end;
    logic         w_ack_to;
    logic         w_done_to;
    logic         w_gap_end;

    clock_spi_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (32)
    ) u_fifo (
        .clk        (FPGA_48MHz),
        .rst_n      (FPGA_rst),
        .i_wr       (bus.cmd_wr),
        .i_wr_data  (bus.cmd_data),
        .i_rd       (w_pop),
        .o_rd_data  (w_fifo_data),
        .o_empty    (w_fifo_empty),
        .o_full     (bus.cmd_full),
        .o_level    (bus.cmd_level)
    );

    // Timer value counts clocks already spent in the current state, minus one
    assign w_tmr_inc   = {1'b0, r_tmr} + (c_TMR_W + 1)'(1);
    assign w_start_end = w_tmr_inc >= {1'b0, c_START_W};
    assign w_ack_to    = w_tmr_inc >= {1'b0, ACK_TIMEOUT};
    assign w_done_to   = w_tmr_inc >= {1'b0, DONE_TIMEOUT};
    assign w_gap_end   = w_tmr_inc >= {9'd0, GAP_CYCLES};

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_set_err   = 1'b0;
        w_set_rsp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Busy high after power-up means the controller is still initialising
                if (!w_fifo_empty && !bus.spi_busy && !r_rsp_valid)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_start_end) w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.spi_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_ack_to) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.spi_busy) begin
                    w_state_nxt = ST_CAPTURE;
                end else if (w_done_to) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_CAPTURE: begin
                w_set_rsp   = is_read_cmd(r_wr_data);
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge FPGA_48MHz or negedge FPGA_rst) begin
        if (!FPGA_rst) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge FPGA_48MHz or negedge FPGA_rst) begin
        if (!FPGA_rst)                  r_tmr <= '0;
        else if (w_state_nxt != r_state) r_tmr <= '0;
        else if (r_tmr != '1)           r_tmr <= r_tmr + tmr_t'(1);
    end

    // spi_start is registered from the next state so it tracks START exactly, glitch-free
    always_ff @(posedge FPGA_48MHz or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            r_spi_start <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_spi_start <= (w_state_nxt == ST_START);
            if (r_state == ST_LOAD) r_wr_data <= w_fifo_data;
        end
    end

    always_ff @(posedge FPGA_48MHz or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_set_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= bus.spi_read_data;
            end else if (bus.rsp_ack) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_set_err)        r_timeout_err <= 1'b1;
            else if (bus.err_clr) r_timeout_err <= 1'b0;
        end
    end

    assign bus.spi_start      = r_spi_start;
    assign bus.spi_write_data = r_wr_data;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.timeout_err    = r_timeout_err;
    assign bus.seq_idle       = (r_state == ST_IDLE) && w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_clock_spi_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_clock_spi_cmd_seq                                       |
// | Brief   : Scoreboard bench with a simple SPI-controller busy model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_clock_spi_cmd_seq;
    import clock_spi_pkg::*;

    localparam int c_START_W = 3;
    localparam int c_GAP     = 8;
    localparam int c_ACK_TO  = 64;

    logic        clk;
    logic        rst_n;
    logic        frc_busy;
    logic        mdl_busy;
    logic        mdl_en;
    logic [31:0] mdl_rd;
    int          mdl_ack_dly;
    int          mdl_busy_len;

    int          n_vec;
    int          n_err;
    int          st_cnt;
    int          s0;
    int          n;
    logic        st_q;
    logic        rv_q;
    logic        m_q;
    int          sw;
    logic [31:0] d;

    logic [31:0] exp_wr[$];
    logic [31:0] exp_rsp[$];

    clock_spi_cmd_seq_if bus();

    assign bus.spi_busy      = frc_busy | mdl_busy;
    assign bus.spi_read_data = mdl_rd;

    clock_spi_cmd_seq #(
        .FIFO_DEPTH   (4),
        .START_WIDTH  (c_START_W),
        .ACK_TIMEOUT  (16'd64),
        .DONE_TIMEOUT (16'd60000),
        .GAP_CYCLES   (8'd8)
    ) dut (
        .FPGA_48MHz (clk),
        .FPGA_rst   (rst_n),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        bus.cmd_wr   = 1'b1;
        bus.cmd_data = w;
        @(negedge clk);
        bus.cmd_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (!bus.seq_idle && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.seq_idle), 32'd1);
    endtask

    // Controller model: busy rises some clocks after a start pulse, then falls
    initial begin
        mdl_busy = 1'b0;
        m_q      = 1'b0;
        forever begin
            @(negedge clk);
            if (mdl_en && bus.spi_start && !m_q) begin
                repeat (mdl_ack_dly) @(posedge clk);
                #1 mdl_busy = 1'b1;
                repeat (mdl_busy_len) @(posedge clk);
                #1 mdl_busy = 1'b0;
                m_q = 1'b0;
            end else begin
                m_q = bus.spi_start;
            end
        end
    end

    // Output monitor: transactions and responses are popped from the scoreboard
    initial begin
        st_q   = 1'b0;
        rv_q   = 1'b0;
        sw     = 0;
        st_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.spi_start && !st_q) begin
                st_cnt++;
                sw = 1;
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) chk("wr_data", bus.spi_write_data, exp_wr.pop_front());
            end else if (bus.spi_start) begin
                sw++;
            end else if (st_q) begin
                chk("start_width", 32'(sw), 32'(c_START_W));
            end
            st_q = bus.spi_start;
            if (bus.rsp_valid && !rv_q) begin
                chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
                if (exp_rsp.size() != 0) chk("rsp_data", bus.rsp_data, exp_rsp.pop_front());
            end
            rv_q = bus.rsp_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        frc_busy     = 1'b0;
        mdl_en       = 1'b1;
        mdl_rd       = 32'h0;
        mdl_ack_dly  = 2;
        mdl_busy_len = 5;
        bus.cmd_wr   = 1'b0;
        bus.cmd_data = 32'h0;
        bus.rsp_ack  = 1'b0;
        bus.err_clr  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_start", 32'(bus.spi_start), 32'd0);
        chk("rst_wdata", bus.spi_write_data, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_level", 32'(bus.cmd_level), 32'd0);
        chk("rst_full", 32'(bus.cmd_full), 32'd0);
        chk("rst_idle", 32'(bus.seq_idle), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Long write transaction, no response expected
        mdl_busy_len = 200;
        s0 = st_cnt;
        exp_wr.push_back(32'h69840301);
        push(32'h69840301);
        n = 0;
        while (!bus.spi_busy && n < 100) begin @(negedge clk); n++; end
        chk("t1_busy_rise", 32'(bus.spi_busy), 32'd1);
        n = 0;
        while (bus.spi_busy && n < 400) begin @(negedge clk); n++; end
        chk("t1_busy_fall", 32'(bus.spi_busy), 32'd0);
        n = 0;
        while (!bus.seq_idle && n < 100) begin @(negedge clk); n++; end
        chk("t1_idle_lat", 32'(n), 32'(c_GAP + 2));
        chk("t1_starts", 32'(st_cnt), 32'(s0 + 1));
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t1_wdata_held", bus.spi_write_data, 32'h69840301);

        // Read command holds off the next queued command until acknowledged
        mdl_busy_len = 5;
        mdl_rd = 32'h00001000;
        s0 = st_cnt;
        exp_wr.push_back(32'h0000008e);
        exp_rsp.push_back(32'h00001000);
        push(32'h0000008e);
        exp_wr.push_back(32'h12345670);
        push(32'h12345670);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        repeat (50) @(negedge clk);
        chk("t2_hold_starts", 32'(st_cnt), 32'(s0 + 1));
        chk("t2_hold_level", 32'(bus.cmd_level), 32'd1);
        chk("t2_hold_data", bus.rsp_data, 32'h00001000);
        bus.rsp_ack = 1'b1;
        @(negedge clk);
        bus.rsp_ack = 1'b0;
        chk("t2_ack_clr", 32'(bus.rsp_valid), 32'd0);
        wait_idle("t2_idle", 200);
        chk("t2_starts", 32'(st_cnt), 32'(s0 + 2));
        chk("t2_rsp_kept", bus.rsp_data, 32'h00001000);
        chk("t2_rsp_valid_off", 32'(bus.rsp_valid), 32'd0);

        // Overflow: fifth push is dropped, four run in order
        frc_busy = 1'b1;
        s0 = st_cnt;
        for (int i = 0; i < 5; i++) begin
            d = 32'hC0DE0003 | (32'(i) << 8);
            if (i < 4) exp_wr.push_back(d);
            push(d);
            if (i == 2) chk("t3_not_full", 32'(bus.cmd_full), 32'd0);
            if (i == 3) chk("t3_full4", 32'(bus.cmd_full), 32'd1);
        end
        chk("t3_level", 32'(bus.cmd_level), 32'd4);
        chk("t3_full5", 32'(bus.cmd_full), 32'd1);
        frc_busy = 1'b0;
        wait_idle("t3_idle", 400);
        chk("t3_starts", 32'(st_cnt), 32'(s0 + 4));
        chk("t3_q_empty", 32'(exp_wr.size()), 32'd0);

        // Controller never answers: acknowledge timeout
        mdl_en = 1'b0;
        exp_wr.push_back(32'h11111110);
        push(32'h11111110);
        n = 0;
        while (!bus.spi_start && n < 20) begin @(negedge clk); n++; end
        chk("t4_start", 32'(bus.spi_start), 32'd1);
        n = 0;
        while (bus.spi_start && n < 20) begin @(negedge clk); n++; end
        chk("t4_start_end", 32'(bus.spi_start), 32'd0);
        n = 0;
        while (!bus.timeout_err && n < 200) begin @(negedge clk); n++; end
        chk("t4_err", 32'(bus.timeout_err), 32'd1);
        chk("t4_err_lat", 32'(n), 32'(c_ACK_TO));
        wait_idle("t4_idle", 50);
        chk("t4_err_sticky", 32'(bus.timeout_err), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t4_err_clr", 32'(bus.timeout_err), 32'd0);
        mdl_en = 1'b1;

        // Reset in WAIT_DONE drops the queued command
        mdl_busy_len = 500;
        s0 = st_cnt;
        exp_wr.push_back(32'h22222220);
        push(32'h22222220);
        n = 0;
        while (!bus.spi_busy && n < 100) begin @(negedge clk); n++; end
        chk("t5_busy", 32'(bus.spi_busy), 32'd1);
        repeat (5) @(negedge clk);
        push(32'h33333330);
        chk("t5_level", 32'(bus.cmd_level), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_start", 32'(bus.spi_start), 32'd0);
        chk("t5_rst_wdata", bus.spi_write_data, 32'd0);
        chk("t5_rst_rsp_data", bus.rsp_data, 32'd0);
        chk("t5_rst_level", 32'(bus.cmd_level), 32'd0);
        chk("t5_rst_idle", 32'(bus.seq_idle), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.spi_busy && n < 600) begin @(negedge clk); n++; end
        chk("t5_busy_fall", 32'(bus.spi_busy), 32'd0);
        repeat (50) @(negedge clk);
        chk("t5_no_start", 32'(st_cnt), 32'(s0 + 1));
        chk("t5_idle", 32'(bus.seq_idle), 32'd1);

        // Power-on init: busy held high keeps queued commands waiting
        mdl_busy_len = 6;
        rst_n = 1'b0;
        frc_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s0 = st_cnt;
        exp_wr.push_back(32'h44444440);
        push(32'h44444440);
        exp_wr.push_back(32'h55555551);
        push(32'h55555551);
        repeat (1000) @(negedge clk);
        chk("t6_wait_starts", 32'(st_cnt), 32'(s0));
        chk("t6_wait_level", 32'(bus.cmd_level), 32'd2);
        frc_busy = 1'b0;
        wait_idle("t6_idle", 300);
        chk("t6_starts", 32'(st_cnt), 32'(s0 + 2));
        chk("t6_q_empty", 32'(exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_spi_cmd_seq.md
CLOCK_SPI_CMD_SEQ -- requirements
Module: clock_spi_cmd_seq

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter START_WIDTH, default 3, meaning spi_start high-pulse length in clocks.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16'd64, meaning clocks allowed for spi_busy to rise after start.
REQ-004 The block SHALL have parameter DONE_TIMEOUT, default 16'd60000, meaning clocks allowed for spi_busy to fall.
REQ-005 The block SHALL have parameter GAP_CYCLES, default 8'd8, meaning idle clocks between transactions.
REQ-006 The block SHALL have these ports, clock and reset first:
 FPGA_48MHz  in  1  sole clock; one clock, all logic on rising edge
 FPGA_rst  in  1  reset, asynchronous, active-low
 cmd_wr  in  1  push cmd_data into FIFO
 cmd_data  in  32  SPI command word for the CDCE62005 controller
 cmd_full  out  1  FIFO full
 cmd_level  out  5  FIFO occupancy
 spi_start  out  1  transaction trigger to controller (rising edge used)
 spi_write_data  out  32  word presented to controller
 spi_busy  in  1  controller busy
 spi_read_data  in  32  controller read result
 rsp_valid  out  1  response word held
 rsp_data  out  32  captured spi_read_data
 rsp_ack  in  1  consumer acknowledge
 timeout_err  out  1  sticky timeout flag
 err_clr  in  1  clears timeout_err
 seq_idle  out  1  FSM in IDLE and FIFO empty

Function
REQ-007 cmd_wr with cmd_full=0 SHALL push cmd_data; cmd_wr with cmd_full=1 SHALL be dropped, with FIFO contents unchanged.
REQ-008 A simultaneous push and pop SHALL leave cmd_level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 The FSM SHALL have states IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, CAPTURE, GAP.
REQ-010 IDLE->LOAD SHALL occur when the FIFO is non-empty, spi_busy=0 and rsp_valid=0; this covers power-on init, where busy is high.
REQ-011 LOAD SHALL pop one word into spi_write_data, hold it until the next LOAD, and go to START next clock.
REQ-012 START SHALL drive spi_start=1 for exactly START_WIDTH clocks, then go to WAIT_ACK; spi_start SHALL be 0 in all other states.
REQ-013 WAIT_ACK SHALL go to WAIT_DONE on spi_busy=1; after ACK_TIMEOUT clocks without it, it SHALL set timeout_err and go to GAP.
REQ-014 WAIT_DONE SHALL go to CAPTURE on spi_busy=0; after DONE_TIMEOUT clocks without it, it SHALL set timeout_err and go to GAP.
REQ-015 CAPTURE SHALL apply only if spi_write_data[3:0]==4'he (read command): load rsp_data<=spi_read_data and set rsp_valid; otherwise rsp is untouched. CAPTURE SHALL then go to GAP.
REQ-016 GAP SHALL hold for GAP_CYCLES clocks and then go to IDLE.
REQ-017 rsp_valid SHALL clear the clock after rsp_ack=1; rsp_ack with rsp_valid=0 SHALL be ignored.
REQ-018 rsp_ack and set in the same clock SHALL leave rsp_valid set; this cannot occur, since set requires the IDLE gate.
REQ-019 The single 16-bit timeout counter SHALL clear on each state entry and saturate.
REQ-020 err_clr SHALL clear timeout_err; a simultaneous set SHALL win.
REQ-021 Minimum transaction latency from pop to IDLE SHALL be 1+START_WIDTH+2+1+GAP_CYCLES clocks plus controller busy time.

Reset
REQ-022 Asserting FPGA_rst low SHALL asynchronously force IDLE, empty the FIFO, and clear spi_start=0, spi_write_data=0, rsp_valid=0, rsp_data=0, timeout_err=0, cmd_level=0, cmd_full=0.
REQ-023 Under reset seq_idle SHALL be 1.
REQ-024 A reset mid-transaction SHALL abort the transaction and lose the queued commands.
REQ-025 Release of reset SHALL be followed by waiting in IDLE while spi_busy=1.

Structure
REQ-026 FSM state encoding, the 4'he read-address constant and the timeout widths SHALL live in shared package clock_spi_pkg.
REQ-027 The FIFO SHALL be a separate sub-module, clock_spi_cmd_fifo (sync FIFO, level and full outputs).
REQ-028 The RTL SHALL contain no latches and no derived clocks.

Verification
REQ-029 Push 32'h69840301 with busy model high for 200 clocks -> one 3-clock spi_start pulse, spi_write_data=32'h69840301, back in IDLE GAP_CYCLES after busy falls, rsp_valid stays 0.
REQ-030 Push 32'h0000008e with read model returning 32'h00001000 -> rsp_valid=1 and rsp_data=32'h00001000; the next queued command waits until rsp_ack.
REQ-031 Push 5 words at depth 4 -> cmd_full after the 4th, the 5th is dropped, and exactly 4 transactions run in push order.
REQ-032 spi_busy stuck low -> timeout_err set 64 clocks after WAIT_ACK entry, FSM reaches IDLE, err_clr clears the flag.
REQ-033 Reset asserted during WAIT_DONE -> all outputs at reset values immediately; a queued command is not issued after release.
REQ-034 Hold spi_busy=1 for 1000 clocks after reset (init sequence) with 2 words queued -> no spi_start until busy falls.
